// File: rtl/simon_inv_key_schedule_serial.sv
// simon_inv_key_schedule_serial: bit-serial inverse Simon 128/128 key schedule; define SIMON_INV_KS_RESTART_EN for shadow-key restart
module simon_inv_key_schedule_serial #(
    parameter int          WORD    = 64,
    parameter int          ROUNDS  = 68,
    parameter logic [61:0] Z_SEQ   = 62'b10101111011100000011010010011000101000010001111110010110110011,
    parameter int          Z_START = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_data_in,
    input  logic       i_load_valid,
    input  logic       i_key_ready,
`ifdef SIMON_INV_KS_RESTART_EN
    input  logic       i_restart,
`endif
    output logic       o_key_out,
    output logic       o_key_valid,
    output logic [6:0] o_round_idx,
    output logic       o_busy,
    output logic       o_done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EMIT_A, S_EMIT_B, S_GEN, S_DONE} state_t;
    state_t          r_state, w_next;
    logic [WORD-1:0] r_a, r_b;
    logic [3:0]      r_wrap;
    logic [6:0]      r_cnt, r_round;
    logic [5:0]      r_zp;
    logic [5:0]      w_j;
    logic [1:0]      w_i3;
    logic            w_emit, w_fire, w_last, w_s3, w_s4, w_z, w_n, w_restart;
`ifdef SIMON_INV_KS_RESTART_EN
    logic [2*WORD-1:0] r_shadow;
    assign w_restart = i_restart;
`else
    assign w_restart = 1'b0;
`endif
    assign w_emit = (r_state == S_EMIT_A) || (r_state == S_EMIT_B) || (r_state == S_GEN);
    assign w_fire = w_emit && i_key_ready;
    assign w_j    = r_cnt[5:0];
    assign w_last = &w_j;
    assign w_i3   = w_j[1:0] + 2'd3;
    // Near the top of the word the needed B bits have shifted out; take them from the wrap buffer
    assign w_s3   = (w_j <= 6'd60) ? r_b[3] : r_wrap[w_i3];
    assign w_s4   = (w_j <= 6'd59) ? r_b[4] : r_wrap[w_j[1:0]];
    assign w_z    = Z_SEQ[6'd61 - r_zp];
    assign w_n    = r_a[0] ^ w_s3 ^ w_s4 ^ (w_j >= 6'd2) ^ ((w_j == 6'd0) & w_z);
    assign o_round_idx = r_round;
    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    // Next-state logic: load 128 bits, emit the two loaded keys, then regenerate down to k[0]
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_start ? S_LOAD : (w_restart ? S_EMIT_A : S_IDLE);
            S_LOAD:   w_next = (i_load_valid && r_cnt == 7'd127) ? S_EMIT_A : S_LOAD;
            S_EMIT_A: w_next = (w_fire && w_last) ? S_EMIT_B : S_EMIT_A;
            S_EMIT_B: w_next = (w_fire && w_last) ? S_GEN : S_EMIT_B;
            S_GEN:    w_next = (w_fire && w_last && r_round == 7'd0) ? S_DONE : S_GEN;
            default:  w_next = S_IDLE;
        endcase
    end
    // Outputs decoded from the current state
    always_comb begin
        o_key_valid = w_emit;
        o_key_out   = (r_state == S_EMIT_A) ? r_a[0] :
                      (r_state == S_EMIT_B) ? r_b[0] :
                      (r_state == S_GEN)    ? w_n    : 1'b0;
        o_busy      = r_state != S_IDLE;
        o_done      = r_state == S_DONE;
    end
    // Bit counter, round index and z pointer
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_round <= '0;
            r_zp    <= '0;
        end else begin
            if ((r_state == S_LOAD && i_load_valid) || w_fire) r_cnt <= r_cnt + 7'd1;
            if (r_state == S_IDLE) r_cnt <= '0;
            if (w_next == S_EMIT_A && r_state != S_EMIT_A) r_round <= 7'(ROUNDS - 1);
            if (w_fire && w_last && r_state == S_EMIT_A) r_round <= 7'(ROUNDS - 2);
            if (w_fire && w_last && r_state == S_EMIT_B) begin
                r_round <= 7'(ROUNDS - 3);
                r_zp    <= 6'(Z_START);
            end
            if (w_fire && w_last && r_state == S_GEN && r_round != 7'd0) begin
                r_round <= r_round - 7'd1;
                r_zp    <= (r_zp == 6'd0) ? 6'd61 : r_zp - 6'd1;
            end
        end
    end
    // Key storage: serial load, rotate-on-emit, and inverse-recurrence shift during GEN
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (r_state == S_LOAD && i_load_valid && r_cnt[6])  r_a <= {i_data_in, r_a[WORD-1:1]};
            if (r_state == S_LOAD && i_load_valid && !r_cnt[6]) r_b <= {i_data_in, r_b[WORD-1:1]};
            if (w_fire && r_state == S_EMIT_A) r_a <= {r_a[0], r_a[WORD-1:1]};
            if (w_fire && r_state == S_EMIT_B) r_b <= {r_b[0], r_b[WORD-1:1]};
            if (w_fire && r_state == S_GEN) begin
                r_a <= {r_b[0], r_a[WORD-1:1]};
                r_b <= {w_n, r_b[WORD-1:1]};
                if (w_j == 6'd0) r_wrap <= r_b[3:0];
            end
`ifdef SIMON_INV_KS_RESTART_EN
            if (r_state == S_IDLE && !i_start && i_restart) {r_a, r_b} <= r_shadow;
            if (r_state == S_LOAD && i_load_valid && r_cnt == 7'd127) r_shadow <= {i_data_in, r_a[WORD-1:1], r_b};
`endif
        end
    end
endmodule

// File: tb/tb_simon_inv_key_schedule_serial.sv
// tb_simon_inv_key_schedule_serial: scoreboard bench for the serial inverse Simon key schedule
module tb_simon_inv_key_schedule_serial;
    logic       clk = 1'b0;
    logic       rst_n, start, din, lv, kr, ko, kv, busy, done;
    logic [6:0] ridx;
`ifdef SIMON_INV_KS_RESTART_EN
    logic       restart;
`endif
    always #5 clk = ~clk;

    simon_inv_key_schedule_serial dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_data_in    (din),
        .i_load_valid (lv),
        .i_key_ready  (kr),
`ifdef SIMON_INV_KS_RESTART_EN
        .i_restart    (restart),
`endif
        .o_key_out    (ko),
        .o_key_valid  (kv),
        .o_round_idx  (ridx),
        .o_busy       (busy),
        .o_done       (done)
    );

    int          n_chk = 0, n_fail = 0;
    logic [63:0] k [0:67];
    logic [63:0] q [$];
    logic [63:0] mword;
    int          mbits = 0, mwords = 0, mdone = 0;
    logic        prev_stall = 1'b0, prev_bit = 1'b0;
    logic [61:0] zs = 62'b10101111011100000011010010011000101000010001111110010110110011;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic push_keys();
        for (int i = 67; i >= 0; i--) q.push_back(k[i]);
        mbits = 0;
        mwords = 0;
        mdone = 0;
        prev_stall = 1'b0;
    endtask

    // Monitor: rebuild each emitted word LSB first and compare against the scoreboard
    always @(negedge clk) begin
        if (prev_stall) chk("hold", 64'(ko), 64'(prev_bit));
        prev_stall = rst_n && kv && !kr;
        prev_bit = ko;
        if (done) mdone++;
        if (rst_n && kv && kr) begin
            if (mbits == 0) chk("round", 64'(ridx), 64'(67 - mwords));
            mword = {ko, mword[63:1]};
            mbits++;
            if (mbits == 64) begin
                mbits = 0;
                mwords++;
                if (q.size() == 0) chk("sb_size", 64'(q.size()), 64'd1);
                else chk("key", mword, q.pop_front());
            end
        end
    end

    task automatic load(input bit toggle);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_load", 64'(busy), 64'd1);
        for (int b = 0; b < 128; b++) begin
            lv = 1'b1;
            din = (b < 64) ? k[66][b] : k[67][b - 64];
            if (b == 127) chk("pre_emit", 64'(kv), 64'd0);
            @(posedge clk); #1;
            if (toggle && b < 127) begin
                lv = 1'b0;
                din = 1'b0;
                @(posedge clk); #1;
            end
        end
        lv = 1'b0;
        din = 1'b0;
        chk("emit_a", 64'(kv), 64'd1);
        chk("round_a", 64'(ridx), 64'd67);
        push_keys();
    endtask

    // mode 0: always ready, 1: random ready in GEN, 2: start pulses mid-stream, 3: reset at k[30] bit 17
    task automatic run(input int mode);
        int cyc = 0;
        bit hit = 1'b0;
        while (!done && cyc < 20000) begin
            kr = (mode == 1 && ridx <= 7'd65) ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (mode == 2) && ((ridx == 7'd66 && mbits == 5) || (ridx == 7'd40 && mbits == 9));
            if (mode == 3 && ridx == 7'd30 && mbits == 17) begin
                hit = 1'b1;
                rst_n = 1'b0;
                @(posedge clk); #1;
                chk("rst_valid", 64'(kv), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_round", 64'(ridx), 64'd0);
                chk("rst_out", 64'(ko), 64'd0);
                rst_n = 1'b1;
                q.delete();
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        kr = 1'b1;
        if (mode == 3) chk("rst_hit", 64'(hit), 64'd1);
        if (mode == 0) chk("done_cyc", 64'(cyc), 64'd4352);
        @(posedge clk); #1;
        chk("done_pulses", 64'(mdone), 64'd1);
        chk("done_clr", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("round_idle", 64'(ridx), 64'd0);
        chk("drained", 64'(q.size()), 64'd0);
        chk("words", 64'(mwords), 64'd68);
    endtask

    initial begin
        k[0] = 64'h0706050403020100;
        k[1] = 64'h0f0e0d0c0b0a0908;
        for (int i = 0; i < 66; i++)
            k[i + 2] = 64'hFFFF_FFFF_FFFF_FFFC ^ {63'd0, zs[61 - (i % 62)]} ^ k[i] ^ ror(k[i + 1], 3) ^ ror(k[i + 1], 4);
        rst_n = 1'b0;
        start = 1'b0;
        din = 1'b0;
        lv = 1'b0;
        kr = 1'b1;
`ifdef SIMON_INV_KS_RESTART_EN
        restart = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_kv", 64'(kv), 64'd0);
        chk("rst_ko", 64'(ko), 64'd0);
        chk("rst_busy0", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ridx", 64'(ridx), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load(1'b0);
        run(0);
        load(1'b1);
        run(0);
        load(1'b0);
        run(1);
        load(1'b0);
        run(3);
        load(1'b0);
        run(0);
        load(1'b0);
        run(2);
`ifdef SIMON_INV_KS_RESTART_EN
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        chk("rs_emit", 64'(kv), 64'd1);
        chk("rs_round", 64'(ridx), 64'd67);
        push_keys();
        run(0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
